// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - frame-synchronous screen selector and RGB mux (optional FADE_EN fade-out)
// Screen requests are latched and applied on frame_tick; WIN/LOSE are held for HOLD_FRAMES frames.
module screen_sequencer #(
   parameter int HOLD_FRAMES = 180,
   parameter int CW          = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        start_btn,
   input  logic        victory_evt,
   input  logic        defeat_evt,
   input  logic [23:0] rgb_title,
   input  logic [23:0] rgb_game,
   input  logic [23:0] rgb_win,
   input  logic [23:0] rgb_lose,
   output logic [7:0]  R,
   output logic [7:0]  G,
   output logic [7:0]  B,
   output logic [1:0]  screen_sel,
   output logic        game_active
);

   typedef enum logic [1:0] {
      S_TITLE = 2'd0,
      S_PLAY  = 2'd1,
      S_WIN   = 2'd2,
      S_LOSE  = 2'd3
   } state_t;

   state_t         state;
   state_t         pend_state;
   state_t         req_state;
   logic           pend_valid;
   logic           req_valid;
   logic           start_q;
   logic           start_edge;
   logic [CW-1:0]  frame_cnt;
   logic [23:0]    rgb_sel;
   logic [3:0]     shift;

   assign start_edge = start_btn & ~start_q;
   assign screen_sel = state;

   // Request seen this cycle; an already latched request always wins.
   always_comb begin
      req_valid = pend_valid;
      req_state = pend_state;
      if (!pend_valid) begin
         if (state == S_TITLE && start_edge) begin
            req_valid = 1'b1;
            req_state = S_PLAY;
         end else if (state == S_PLAY && victory_evt) begin
            req_valid = 1'b1;
            req_state = S_WIN;
         end else if (state == S_PLAY && defeat_evt) begin
            req_valid = 1'b1;
            req_state = S_LOSE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_TITLE;
         pend_valid  <= 1'b0;
         pend_state  <= S_TITLE;
         frame_cnt   <= '0;
         start_q     <= 1'b0;
         game_active <= 1'b0;
      end else begin
         start_q <= start_btn;
         if (frame_tick) begin
            pend_valid <= 1'b0;
            if (req_valid) begin
               state       <= req_state;
               frame_cnt   <= '0;
               game_active <= (req_state == S_PLAY);
            end else if (state == S_WIN || state == S_LOSE) begin
               if (frame_cnt == CW'(HOLD_FRAMES - 1)) begin
                  state     <= S_TITLE;
                  frame_cnt <= '0;
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end
         end else begin
            pend_valid <= req_valid;
            pend_state <= req_state;
         end
      end
   end

   always_comb begin
      case (state)
         S_TITLE: rgb_sel = rgb_title;
         S_PLAY:  rgb_sel = rgb_game;
         S_WIN:   rgb_sel = rgb_win;
         default: rgb_sel = rgb_lose;
      endcase
   end

`ifdef FADE_EN
   // Last eight held frames dim by one extra bit each, reaching black on the final frame.
   always_comb begin
      shift = 4'd0;
      if ((state == S_WIN || state == S_LOSE) && frame_cnt >= CW'(HOLD_FRAMES - 8))
         shift = 4'(frame_cnt - CW'(HOLD_FRAMES - 8)) + 4'd1;
   end
`else
   assign shift = 4'd0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         R <= 8'h00;
         G <= 8'h00;
         B <= 8'h00;
      end else begin
         R <= rgb_sel[23:16] >> shift;
         G <= rgb_sel[15:8]  >> shift;
         B <= rgb_sel[7:0]   >> shift;
      end
   end

endmodule
